// File: rtl/ascii_pkg.sv
// rtl/ascii_pkg.sv - ASCII byte constants and FSM state type shared by the number accumulator
package ascii_pkg;

   localparam logic [7:0] ASCII_ZERO = 8'h30;
   localparam logic [7:0] ASCII_NINE = 8'h39;
   localparam logic [7:0] ASCII_CR   = 8'h0D;
   localparam logic [7:0] ASCII_LF   = 8'h0A;
   localparam logic [7:0] ASCII_SP   = 8'h20;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACCUM   = 2'd1,
      DISCARD = 2'd2
   } acc_state_e;

endpackage

// File: rtl/ascii_digit_classify.sv
// rtl/ascii_digit_classify.sv - combinational byte classifier: decimal digit, terminator or illegal
module ascii_digit_classify
   import ascii_pkg::*;
(
   input  logic [7:0] rx_data,
   output logic [3:0] digit,
   output logic       is_digit,
   output logic       is_term
);

   assign digit    = rx_data[3:0];
   assign is_digit = (rx_data >= ASCII_ZERO) && (rx_data <= ASCII_NINE);
   assign is_term  = (rx_data == ASCII_CR) || (rx_data == ASCII_LF) || (rx_data == ASCII_SP);

endmodule

// File: rtl/ascii_number_accumulator.sv
// rtl/ascii_number_accumulator.sv - assembles an MSD-first ASCII decimal number into a binary value
module ascii_number_accumulator
   import ascii_pkg::*;
#(
   parameter int MAX_DIGITS = 5,
   parameter int OUT_W      = 20
)
(
   input  logic             clk,
   input  logic             reset,
   input  logic [7:0]       rx_data,
   input  logic             rx_valid,
   output logic [OUT_W-1:0] value,
   output logic             value_valid,
   output logic             error,
   output logic             busy,
   output logic [2:0]       digit_count
);

   acc_state_e       state_q, state_d;
   logic [OUT_W-1:0] acc_q, acc_d;
   logic [OUT_W-1:0] value_q, value_d;
   logic [2:0]       count_q, count_d;
   logic             vv_q, vv_d;
   logic             err_q, err_d;

   logic [3:0]       digit;
   logic             is_digit;
   logic             is_term;
   logic [OUT_W-1:0] digit_ext;
   logic [OUT_W-1:0] acc_next;

   ascii_digit_classify u_classify (
      .rx_data  (rx_data),
      .digit    (digit),
      .is_digit (is_digit),
      .is_term  (is_term)
   );

   // acc*10 + digit as two shifts and adds, truncated to OUT_W
   assign digit_ext = {{(OUT_W-4){1'b0}}, digit};
   assign acc_next  = (acc_q << 3) + (acc_q << 1) + digit_ext;

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      value_d = value_q;
      count_d = count_q;
      vv_d    = 1'b0;
      err_d   = 1'b0;
      if (rx_valid) begin
         unique case (state_q)
            IDLE: begin
               if (is_digit) begin
                  acc_d   = digit_ext;
                  count_d = 3'd1;
                  state_d = ACCUM;
               end else if (!is_term) begin
                  state_d = DISCARD;
               end
            end
            ACCUM: begin
               if (is_digit) begin
                  if (count_q == 3'(MAX_DIGITS)) begin
                     state_d = DISCARD;
                  end else begin
                     acc_d   = acc_next;
                     count_d = count_q + 3'd1;
                  end
               end else if (is_term) begin
                  value_d = acc_q;
                  vv_d    = 1'b1;
                  acc_d   = '0;
                  count_d = 3'd0;
                  state_d = IDLE;
               end else begin
                  state_d = DISCARD;
               end
            end
            DISCARD: begin
               if (is_term) begin
                  err_d   = 1'b1;
                  acc_d   = '0;
                  count_d = 3'd0;
                  state_d = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         acc_q   <= '0;
         value_q <= '0;
         count_q <= 3'd0;
         vv_q    <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         value_q <= value_d;
         count_q <= count_d;
         vv_q    <= vv_d;
         err_q   <= err_d;
      end
   end

   assign value       = value_q;
   assign value_valid = vv_q;
   assign error       = err_q;
   assign busy        = (state_q != IDLE);
   assign digit_count = count_q;

endmodule

// File: tb/tb_ascii_number_accumulator.sv
// tb/tb_ascii_number_accumulator.sv - self-checking bench against a string-level reference model
module tb_ascii_number_accumulator;

   logic        clk;
   logic        reset;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic [19:0] value;
   logic        value_valid;
   logic        error;
   logic        busy;
   logic [2:0]  digit_count;

   int n_tests;
   int n_fail;

   // reference: bytes received since the last terminator, plus last good result
   logic [7:0]  pend_q[$];
   logic [19:0] exp_value;
   logic        exp_vv;
   logic        exp_err;

   ascii_number_accumulator #(.MAX_DIGITS(5), .OUT_W(20)) dut (
      .clk         (clk),
      .reset       (reset),
      .rx_data     (rx_data),
      .rx_valid    (rx_valid),
      .value       (value),
      .value_valid (value_valid),
      .error       (error),
      .busy        (busy),
      .digit_count (digit_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic bit is_dig(input logic [7:0] b);
      return (b >= 8'h30) && (b <= 8'h39);
   endfunction

   function automatic bit is_trm(input logic [7:0] b);
      return (b == 8'h0D) || (b == 8'h0A) || (b == 8'h20);
   endfunction

   task automatic model_step(input logic v, input logic [7:0] b);
      bit ok;
      int num;
      exp_vv  = 1'b0;
      exp_err = 1'b0;
      if (v) begin
         if (is_trm(b)) begin
            if (pend_q.size() > 0) begin
               ok  = (pend_q.size() <= 5);
               num = 0;
               foreach (pend_q[i]) begin
                  if (!is_dig(pend_q[i])) ok = 0;
                  num = num * 10 + int'(pend_q[i] - 8'h30);
               end
               if (ok) begin
                  exp_value = 20'(num);
                  exp_vv    = 1'b1;
               end else begin
                  exp_err = 1'b1;
               end
            end
            pend_q.delete();
         end else begin
            pend_q.push_back(b);
         end
      end
   endtask

   function automatic int exp_count();
      int n = 0;
      foreach (pend_q[i]) begin
         if (!is_dig(pend_q[i])) break;
         n++;
      end
      return (n > 5) ? 5 : n;
   endfunction

   task automatic check_all();
      check("value", 32'(value), 32'(exp_value));
      check("value_valid", 32'(value_valid), 32'(exp_vv));
      check("error", 32'(error), 32'(exp_err));
      check("busy", 32'(busy), 32'(pend_q.size() != 0));
      check("digit_count", 32'(digit_count), 32'(exp_count()));
   endtask

   task automatic send(input logic [7:0] b, input logic v);
      @(negedge clk);
      reset    = 1'b0;
      rx_data  = b;
      rx_valid = v;
      @(posedge clk);
      #1;
      model_step(v, b);
      check_all();
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset    = 1'b1;
      rx_valid = 1'b1;
      rx_data  = 8'h35;
      @(posedge clk);
      #1;
      pend_q.delete();
      exp_value = '0;
      exp_vv    = 1'b0;
      exp_err   = 1'b0;
      check_all();
   endtask

   task automatic send_str(input string s, input int maxgap);
      for (int i = 0; i < s.len(); i++) begin
         send(s[i], 1'b1);
         for (int g = $urandom_range(0, maxgap); g > 0; g--)
            send(8'($urandom), 1'b0);
      end
   endtask

   task automatic directed(input int maxgap);
      send_str("12345\r", maxgap);
      check("t1_value", 32'(value), 32'h03039);
      send_str("99999 ", maxgap);
      check("t2a_value", 32'(value), 32'h1869F);
      send_str("7\n", maxgap);
      check("t2b_value", 32'(value), 32'h00007);
      send_str("123456\r", maxgap);
      check("t3_value_kept", 32'(value), 32'h00007);
      send_str("1A2\r", maxgap);
      send_str("42\r", maxgap);
      check("t4_value", 32'(value), 32'h0002A);
      send_str("\r\r ", maxgap);
      check("t5_busy", 32'(busy), 32'h0);
      send_str("12", maxgap);
      do_reset();
      send_str("7\r", maxgap);
      check("t6_value", 32'(value), 32'h00007);
   endtask

   initial begin
      logic [7:0] b;
      logic [7:0] terms [3];
      int len;
      n_tests  = 0;
      n_fail   = 0;
      reset    = 1'b1;
      rx_data  = 8'h00;
      rx_valid = 1'b0;
      terms[0] = 8'h0D;
      terms[1] = 8'h0A;
      terms[2] = 8'h20;
      exp_value = '0;
      exp_vv    = 1'b0;
      exp_err   = 1'b0;

      do_reset();
      do_reset();
      directed(0);
      directed(3);

      for (int n = 0; n < 300; n++) begin
         if ($urandom_range(0, 24) == 0) do_reset();
         len = $urandom_range(0, 7);
         for (int k = 0; k < len; k++) begin
            if ($urandom_range(0, 19) == 0) begin
               do b = 8'($urandom); while (is_dig(b) || is_trm(b));
            end else begin
               b = 8'h30 + 8'($urandom_range(0, 9));
            end
            send(b, 1'b1);
            for (int g = $urandom_range(0, 3); g > 0; g--)
               send(8'($urandom), 1'b0);
         end
         send(terms[$urandom_range(0, 2)], 1'b1);
         for (int g = $urandom_range(0, 2); g > 0; g--)
            send(8'($urandom), 1'b0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
